// File: rtl/md_issue_ctrl_pkg.sv
// rtl/md_issue_ctrl_pkg.sv - MD op encodings, control codes, default latencies and op-class helpers
package md_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULTU = 4'd1,
    OP_MULT  = 4'd2,
    OP_DIVU  = 4'd3,
    OP_DIV   = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;

  localparam logic [1:0] MDC_MULTU = 2'b00;
  localparam logic [1:0] MDC_MULT  = 2'b01;
  localparam logic [1:0] MDC_DIVU  = 2'b10;
  localparam logic [1:0] MDC_DIV   = 2'b11;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int CNT_W_DEF   = 4;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_MULT);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_MULT) || (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  function automatic logic is_mt(input logic [3:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  // Any op that touches the MD unit or HI/LO; unused encodings count as non-MD.
  function automatic logic is_md_op(input logic [3:0] op);
    return is_muldiv(op) || is_mt(op) || (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

  function automatic logic [1:0] mdc_of(input logic [3:0] op);
    logic [1:0] mdc;
    mdc = MDC_MULTU;
    case (op)
      OP_MULTU: mdc = MDC_MULTU;
      OP_MULT:  mdc = MDC_MULT;
      OP_DIVU:  mdc = MDC_DIVU;
      OP_DIV:   mdc = MDC_DIV;
      default:  mdc = MDC_MULTU;
    endcase
    return mdc;
  endfunction

endpackage

// File: rtl/md_lat_counter.sv
// rtl/md_lat_counter.sv - load/decrement latency counter with zero flag
module md_lat_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over decrement; the count parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - MD issue/hazard controller: E-stage op register, start pulse, latency mirror, decode stall
module md_issue_ctrl
  import md_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] op_D,
  input  logic       stall_ext,
  input  logic       flush_E,
  input  logic       md_busy,
  output logic       Start_E,
  output logic [1:0] MDControl_E,
  output logic       HiLo_E,
  output logic       MDWrite_E,
  output logic       rd_hi_E,
  output logic       rd_lo_E,
  output logic       md_stall_D,
  output logic       md_pending,
  output logic       md_err
);

  logic [3:0]       op_e_q;
  logic [3:0]       op_e_d;
  logic             issued_q;
  logic             issued_d;
  logic             md_err_q;
  logic             md_err_d;
  logic             cnt_zero;
  logic             start_e;
  logic             stall_raw;
  logic             e_hold;
  logic [CNT_W-1:0] lat_val;

  md_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk     (clk),
    .reset   (reset),
    .load    (start_e),
    .load_val(lat_val),
    .zero    (cnt_zero)
  );

  // Start pulse and decode hazard; the counter covers the gap before MD's own busy rises.
  always_comb begin
    start_e   = is_muldiv(op_e_q) && !issued_q && !stall_ext;
    lat_val   = is_mul(op_e_q) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
    stall_raw = is_md_op(op_D) &&
                (!cnt_zero || (is_muldiv(op_e_q) && !issued_q) || is_mt(op_e_q) || md_busy);
  end

  // E register, issue flag and sticky error next-state; a start sets issued even as the op leaves E.
  always_comb begin
    e_hold = stall_ext && !flush_E;
    op_e_d = op_e_q;
    if (flush_E || (stall_raw && !stall_ext)) begin
      op_e_d = OP_NOP;
    end else if (!stall_ext) begin
      op_e_d = op_D;
    end
    issued_d = 1'b0;
    if (start_e) begin
      issued_d = 1'b1;
    end else if (e_hold) begin
      issued_d = issued_q;
    end
    md_err_d = md_err_q || (!md_busy && !cnt_zero);
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_e_q   <= OP_NOP;
      issued_q <= 1'b0;
      md_err_q <= 1'b0;
    end else begin
      op_e_q   <= op_e_d;
      issued_q <= issued_d;
      md_err_q <= md_err_d;
    end
  end

  assign Start_E     = start_e;
  assign MDControl_E = mdc_of(op_e_q);
  assign HiLo_E      = (op_e_q == OP_MTHI);
  assign MDWrite_E   = is_mt(op_e_q) && !stall_ext;
  assign rd_hi_E     = (op_e_q == OP_MFHI);
  assign rd_lo_E     = (op_e_q == OP_MFLO);
  // Gated by reset so the stall, which depends on live inputs, is also 0 while reset is held.
  assign md_stall_D  = stall_raw && reset;
  assign md_pending  = !cnt_zero;
  assign md_err      = md_err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - self-checking bench for md_issue_ctrl
module tb_md_issue_ctrl;

  localparam int LAT_MUL = 5;
  localparam int LAT_DIV = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] op_D;
  logic       stall_ext, flush_E, md_busy;
  logic       Start_E, HiLo_E, MDWrite_E, rd_hi_E, rd_lo_E, md_stall_D, md_pending, md_err;
  logic [1:0] MDControl_E;

  md_issue_ctrl dut (
    .clk(clk), .reset(reset), .op_D(op_D), .stall_ext(stall_ext), .flush_E(flush_E),
    .md_busy(md_busy), .Start_E(Start_E), .MDControl_E(MDControl_E), .HiLo_E(HiLo_E),
    .MDWrite_E(MDWrite_E), .rd_hi_E(rd_hi_E), .rd_lo_E(rd_lo_E), .md_stall_D(md_stall_D),
    .md_pending(md_pending), .md_err(md_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: op in E, whether it was started, absolute completion cycle, sticky error.
  int         cyc = 0;
  logic [3:0] m_opE;
  bit         m_issued;
  int         m_done;
  bit         m_err;

  // MD data mirror.
  logic [31:0] opa = 32'd1, opb = 32'd1, hi_r = '0, lo_r = '0;

  // Outputs captured mid-cycle by cycle().
  logic       o_start, o_stall, o_pend, o_rdhi, o_rdlo, o_err, o_mdw, o_hilo;
  logic [1:0] o_mdc;

  typedef struct {
    logic [3:0] op;
    bit st, fl, busy;
    bit start; logic [1:0] mdc; bit hilo, mdw, rdhi, rdlo, stall, pend;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_is_muldiv(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd4;
  endfunction
  function automatic bit m_is_md(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd8;
  endfunction
  function automatic bit m_is_mt(input logic [3:0] op);
    return op == 4'd7 || op == 4'd8;
  endfunction
  function automatic int m_cnt();
    return (m_done > cyc) ? m_done - cyc : 0;
  endfunction
  function automatic bit m_start(input bit st);
    return m_is_muldiv(m_opE) && !m_issued && !st;
  endfunction
  function automatic bit m_stall(input logic [3:0] op, input bit b);
    return m_is_md(op) && (m_cnt() > 0 || (m_is_muldiv(m_opE) && !m_issued) || m_is_mt(m_opE) || b);
  endfunction
  function automatic logic [9:0] model_vec(input logic [3:0] op, input bit st, input bit b);
    logic [1:0] mdc;
    mdc = m_is_muldiv(m_opE) ? 2'(m_opE - 4'd1) : 2'b00;
    return {m_start(st), mdc, m_opE == 4'd7, m_is_mt(m_opE) && !st, m_opE == 4'd5,
            m_opE == 4'd6, m_stall(op, b), m_cnt() > 0, m_err};
  endfunction
  function automatic logic [9:0] dut_vec();
    return {Start_E, MDControl_E, HiLo_E, MDWrite_E, rd_hi_E, rd_lo_E, md_stall_D, md_pending, md_err};
  endfunction

  task automatic model_reset();
    m_opE = 4'd0; m_issued = 0; m_done = cyc; m_err = 0;
  endtask

  // Mirror the MD arithmetic using the control code the DUT actually drives.
  task automatic md_mirror();
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(opa));
    sb = longint'($signed(opb));
    case (MDControl_E)
      2'b00: begin p = {32'b0, opa} * {32'b0, opb}; hi_r = p[63:32]; lo_r = p[31:0]; end
      2'b01: begin p = 64'(sa * sb); hi_r = p[63:32]; lo_r = p[31:0]; end
      2'b10: begin lo_r = opa / opb; hi_r = opa % opb; end
      default: begin lo_r = 32'(sa / sb); hi_r = 32'(sa % sb); end
    endcase
  endtask

  // One clock cycle: drive at posedge+1, check against the model at the falling edge, advance model at posedge.
  // bsel: 0 = busy forced low, 1 = forced high, 2 = well-behaved MD (busy while latency remains).
  task automatic cycle(input logic [3:0] op, input bit st, input bit fl, input int bsel);
    bit b, s, stl;
    int c;
    c = m_cnt();
    b = (bsel == 2) ? (c > 0) : (bsel == 1);
    op_D = op; stall_ext = st; flush_E = fl; md_busy = b;
    #4;
    o_start = Start_E; o_stall = md_stall_D; o_pend = md_pending; o_rdhi = rd_hi_E;
    o_rdlo = rd_lo_E; o_err = md_err; o_mdw = MDWrite_E; o_hilo = HiLo_E; o_mdc = MDControl_E;
    check("model", dut_vec(), model_vec(op, st, b));
    if (Start_E) md_mirror();
    s   = m_start(st);
    stl = m_stall(op, b);
    @(posedge clk);
    if (!b && c > 0) m_err = 1;
    if (s) m_done = cyc + 1 + ((m_opE <= 4'd2) ? LAT_MUL : LAT_DIV);
    m_issued = s ? 1'b1 : ((st && !fl) ? m_issued : 1'b0);
    if (fl || (stl && !st)) m_opE = 4'd0;
    else if (!st) m_opE = op;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; op_D = 4'd0; stall_ext = 0; flush_E = 0; md_busy = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int starts;
    // Reset state, with an MD op in D and busy high to show the stall is suppressed.
    reset = 1'b0; op_D = 4'd5; stall_ext = 0; flush_E = 0; md_busy = 1;
    #2;
    check("reset_outputs", dut_vec(), 10'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    model_reset();

    // MTHI then MULT, then MULT followed by MFHI, A=-3 B=7.
    opa = 32'hFFFF_FFFD; opb = 32'd7;
    tbl[0]  = '{4'd7, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{4'd2, 0, 0, 0, 0, 2'd0, 1, 1, 0, 0, 1, 0};
    tbl[2]  = '{4'd2, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{4'd5, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0, 1, 0};
    for (int i = 4; i <= 8; i++) tbl[i] = '{4'd5, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 1, 1};
    tbl[9]  = '{4'd5, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{4'd0, 0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].op, tbl[i].st, tbl[i].fl, tbl[i].busy ? 1 : 0);
      check($sformatf("tbl_row%0d", i),
            {o_start, o_mdc, o_hilo, o_mdw, o_rdhi, o_rdlo, o_stall, o_pend, o_err},
            {tbl[i].start, tbl[i].mdc, tbl[i].hilo, tbl[i].mdw, tbl[i].rdhi, tbl[i].rdlo,
             tbl[i].stall, tbl[i].pend, 1'b0});
    end
    check("mult_hi", hi_r, 32'hFFFF_FFFF);
    check("mult_lo", lo_r, 32'hFFFF_FFEB);

    // DIVU 100/7, ALU op flows, MFLO waits 10 cycles.
    opa = 32'd100; opb = 32'd7;
    cycle(4'd3, 0, 0, 2);
    cycle(4'd0, 0, 0, 2);
    check("divu_start", o_start, 1);
    check("alu_not_stalled", o_stall, 0);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(4'd6, 0, 0, 2);
      if (o_stall) n++;
      else break;
    end
    check("mflo_stall_cycles", n, 10);
    cycle(4'd0, 0, 0, 2);
    check("mflo_in_e", o_rdlo, 1);
    check("divu_lo", lo_r, 32'd14);
    check("divu_hi", hi_r, 32'd2);

    // DIV held in E by stall_ext for 3 cycles: one start pulse, 10 pending cycles.
    cycle(4'd4, 0, 0, 2);
    starts = 0;
    repeat (3) begin
      cycle(4'd0, 1, 0, 2);
      starts += int'(o_start);
    end
    check("no_start_while_stalled", starts, 0);
    cycle(4'd0, 0, 0, 2);
    starts += int'(o_start);
    check("div_one_start", starts, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(4'd0, 0, 0, 2);
      starts += int'(o_start);
      if (o_pend) n++;
      else break;
    end
    check("div_pending_cycles", n, 10);
    check("div_total_starts", starts, 1);

    // Start coinciding with flush: start still issued, E empties.
    cycle(4'd2, 0, 0, 2);
    cycle(4'd0, 0, 1, 2);
    check("flush_start", o_start, 1);
    cycle(4'd0, 0, 0, 2);
    check("flush_pending", o_pend, 1);
    check("flush_e_empty", o_mdc, 2'd0);
    repeat (6) cycle(4'd0, 0, 0, 2);

    // Reset while the counter is at 6.
    cycle(4'd4, 0, 0, 2);
    cycle(4'd0, 0, 0, 2);
    repeat (4) cycle(4'd0, 0, 0, 2);
    op_D = 4'd7; md_busy = 1;
    #1;
    check("pre_reset_stall", md_stall_D, 1);
    check("pre_reset_pending", md_pending, 1);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", dut_vec(), 10'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    cycle(4'd6, 0, 0, 0);
    check("post_reset_mflo_free", o_stall, 0);
    check("post_reset_pending", o_pend, 0);

    // MD busy drops early at cnt=3: sticky error until reset.
    cycle(4'd2, 0, 0, 2);
    cycle(4'd0, 0, 0, 2);
    cycle(4'd0, 0, 0, 2);
    cycle(4'd0, 0, 0, 2);
    check("err_before_drop", o_err, 0);
    cycle(4'd0, 0, 0, 0);
    repeat (8) cycle(4'd0, 0, 0, 2);
    check("err_sticky", o_err, 1);
    do_reset();
    check("err_cleared", md_err, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 500; k++) begin
      cycle(4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            ($urandom_range(0, 49) == 0) ? 0 : 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Issue/hazard controller directly upstream of the multiply/divide unit (MD).
- Holds the E-stage MD op register fed from decode and drives MD's Start_E, MDControl_E, HiLo_E and MDWrite_E.
- Mirrors MD latency with its own counter, so decode stalls from the Start_E cycle onward. This closes the one-cycle window before MD's registered busy rises.
- Also generates the E-stage HI/LO read selects for MFHI/MFLO.

Parameters:
- MUL_LAT, 5, cycles from the Start_E sampling edge to the HI/LO write for MULT/MULTU.
- DIV_LAT, 10, same for DIV/DIVU.
- CNT_W, 4, latency counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_D  in  4  decoded MD op in decode (encoding in md_defs.vh).
- stall_ext  in  1  freeze from later stages; holds op_E.
- flush_E  in  1  inject bubble into E.
- md_busy  in  1  busy from MD.
- Start_E  out  1  one-cycle start pulse to MD.
- MDControl_E  out  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- HiLo_E  out  1  1 = HI target for MTHI.
- MDWrite_E  out  1  MTHI/MTLO write strobe.
- rd_hi_E  out  1  MFHI in E.
- rd_lo_E  out  1  MFLO in E.
- md_stall_D  out  1  stall decode.
- md_pending  out  1  counter nonzero.
- md_err  out  1  sticky: MD busy dropped while counter > 0.

Behaviour:
- Reset (reset=0, async): op_E=NOP, issued=0, cnt=0, md_err=0. All outputs 0.
- E register update:
  - flush_E, or (md_stall_D and not stall_ext): op_E <= NOP.
  - stall_ext: op_E held.
  - else: op_E <= op_D.
  - issued clears whenever op_E is loaded.
- Start_E = op_E is MULT/MULTU/DIVU/DIV and !issued and !stall_ext.
  - On the edge sampling Start_E, issued <= 1. Exactly one pulse per issued op, even across stall_ext.
- MDControl_E decodes from op_E and is valid whenever op_E is a mul/div op.
- MDWrite_E = op_E in {MTHI, MTLO} and !stall_ext. HiLo_E = (op_E == MTHI).
- rd_hi_E = (op_E == MFHI); rd_lo_E = (op_E == MFLO).
- Counter:
  - On a Start_E edge: cnt <= MUL_LAT (mult) or DIV_LAT (div).
  - Otherwise, if cnt != 0: cnt <= cnt - 1. It reaches 0 on the same edge at which MD writes HI/LO.
- md_pending = (cnt != 0).
- md_stall_D = op_D is any MD op (mul/div, MFHI, MFLO, MTHI, MTLO) and any of:
  - cnt != 0;
  - Start_E pending (op_E is mul/div and !issued);
  - op_E is MTHI/MTLO;
  - md_busy.
- md_busy is ORed in so a slow or mis-sized MD still stalls safely.
- md_err set when md_busy == 0 and cnt > 0 (MD finished early). Cleared only by reset.
- Simultaneous Start_E and flush_E: the start is still issued (op already in E). The flush takes effect on the following edge.
- Divide by zero: no special case. Same latency; the result is whatever MD produces.
- Reset mid-operation: the counter is abandoned. MD's own reset is the integrator's responsibility.

Decomposition:
- md_defs.vh holds:
  - op encodings: NOP=0, MULTU=1, MULT=2, DIVU=3, DIV=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8;
  - MDControl codes;
  - default MUL_LAT/DIV_LAT.
- One sub-module, md_lat_counter: load/decrement counter with zero flag, parameterised on CNT_W.

Test Plan:
- MULT then MFHI back-to-back:
  - MULT issued in E gives one Start_E pulse; md_stall_D is high that cycle and for the next 5 cycles.
  - MFHI enters E on the cycle after cnt reaches 0 and rd_hi_E=1.
  - Mirror MD with A=-3, B=7: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIVU 100/7 followed by an ALU op and MFLO:
  - The ALU op flows freely.
  - MFLO stalls until 10 edges after Start_E, then reads LO=14 (HI=2).
- stall_ext held 3 cycles while DIV sits in E: exactly one Start_E pulse, and cnt starts at 10 on the first edge.
- MTHI in E followed by MULT in D: MULT stalls one cycle and MDWrite_E=1, HiLo_E=1 for one cycle.
- Reset asserted with cnt=6:
  - All outputs 0 immediately (async).
  - After release, MFLO in D is not stalled while md_busy=0.
- Model md_busy falling at cnt=3: md_err=1 and stays 1 until reset.
